// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: registers decoded fields and control,
// then builds forwarded ALU operands, store data and the load-use hazard flag.
module alu_operand_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic [4:0]  id_rd_dst,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [15:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic        id_ALUSrc1,
   input  logic        id_ALUSrc2,
   input  logic        id_ExtOp,
   input  logic        id_LuOp,
   input  logic [5:0]  id_ALUFun,
   input  logic        id_Sign,
   input  logic        id_RegWrite,
   input  logic        id_MemRead,
   input  logic        id_MemWrite,
   input  logic        exmem_RegWrite,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_RegWrite,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   output logic [31:0] ex_A,
   output logic [31:0] ex_B,
   output logic [5:0]  ex_ALUFun,
   output logic        ex_Sign,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic        ex_RegWrite,
   output logic        ex_MemRead,
   output logic        ex_MemWrite,
   output logic        ex_valid,
   output logic        load_use_hazard
);

   logic        valid_q;
   logic [4:0]  rs_addr_q;
   logic [4:0]  rt_addr_q;
   logic [4:0]  rd_q;
   logic [31:0] rs_data_q;
   logic [31:0] rt_data_q;
   logic [15:0] imm_q;
   logic [4:0]  shamt_q;
   logic        alu_src1_q;
   logic        alu_src2_q;
   logic        ext_op_q;
   logic        lu_op_q;
   logic [5:0]  alu_fun_q;
   logic        sign_q;
   logic        reg_write_q;
   logic        mem_read_q;
   logic        mem_write_q;

   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic [31:0] ext_imm;

   // Reset and flush both load a bubble; stall only matters when neither is set.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid_q     <= 1'b0;
         rs_addr_q   <= 5'd0;
         rt_addr_q   <= 5'd0;
         rd_q        <= 5'd0;
         rs_data_q   <= 32'd0;
         rt_data_q   <= 32'd0;
         imm_q       <= 16'd0;
         shamt_q     <= 5'd0;
         alu_src1_q  <= 1'b0;
         alu_src2_q  <= 1'b0;
         ext_op_q    <= 1'b0;
         lu_op_q     <= 1'b0;
         alu_fun_q   <= 6'd0;
         sign_q      <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else if (!stall) begin
         valid_q     <= id_valid;
         rs_addr_q   <= id_rs_addr;
         rt_addr_q   <= id_rt_addr;
         rd_q        <= id_rd_dst;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         imm_q       <= id_imm;
         shamt_q     <= id_shamt;
         alu_src1_q  <= id_ALUSrc1;
         alu_src2_q  <= id_ALUSrc2;
         ext_op_q    <= id_ExtOp;
         lu_op_q     <= id_LuOp;
         alu_fun_q   <= id_ALUFun;
         sign_q      <= id_Sign;
         reg_write_q <= id_valid & id_RegWrite;
         mem_read_q  <= id_valid & id_MemRead;
         mem_write_q <= id_valid & id_MemWrite;
      end
   end

   // EX/MEM is the younger producer, so it is checked first; $0 never forwards.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == rs_addr_q)) begin
         fwd_rs = exmem_result;
      end else if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == rs_addr_q)) begin
         fwd_rs = memwb_result;
      end
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == rt_addr_q)) begin
         fwd_rt = exmem_result;
      end else if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == rt_addr_q)) begin
         fwd_rt = memwb_result;
      end
   end

   always_comb begin
      if (lu_op_q) begin
         ext_imm = {imm_q, 16'd0};
      end else if (ext_op_q) begin
         ext_imm = {{16{imm_q[15]}}, imm_q};
      end else begin
         ext_imm = {16'd0, imm_q};
      end
   end

   assign ex_A          = alu_src1_q ? {27'd0, shamt_q} : fwd_rs;
   assign ex_B          = alu_src2_q ? ext_imm : fwd_rt;
   assign ex_store_data = fwd_rt;

   assign ex_ALUFun   = alu_fun_q;
   assign ex_Sign     = sign_q;
   assign ex_rd       = rd_q;
   assign ex_RegWrite = reg_write_q;
   assign ex_MemRead  = mem_read_q;
   assign ex_MemWrite = mem_write_q;
   assign ex_valid    = valid_q;

   assign load_use_hazard = mem_read_q && valid_q && (rd_q != 5'd0) &&
                            ((rd_q == id_rs_addr) || (rd_q == id_rt_addr));

endmodule
